// File: rtl/note_voice_if.sv
// note_voice_if: command-in / voice-and-mix-out bundle for note_voice_engine (master drives rx_data/rx_valid, slave drives voice_active, voice_sq, audio_level, audio_out, cmd_drop)
interface note_voice_if #(parameter int NUM_VOICES = 4);
  logic [7:0] rx_data;
  logic rx_valid;
  logic [NUM_VOICES-1:0] voice_active;
  logic [NUM_VOICES-1:0] voice_sq;
  logic [$clog2(NUM_VOICES+1)-1:0] audio_level;
  logic audio_out;
  logic cmd_drop;
  modport master (output rx_data, rx_valid, input voice_active, voice_sq, audio_level, audio_out, cmd_drop);
  modport slave (input rx_data, rx_valid, output voice_active, voice_sq, audio_level, audio_out, cmd_drop);
endinterface

// File: rtl/note_voice_engine.sv
// note_voice_engine: polyphonic note-on/off decoder, voice allocator with stealing and auto-release, square-wave mixer; ports clk, rst, bus (rx_data/rx_valid in; voice_active, voice_sq, audio_level, audio_out, cmd_drop out)
module note_voice_engine #(
  parameter int CLK_HZ = 100_000_000,
  parameter int NUM_VOICES = 4,
  parameter int CNT_W = 26,
  parameter int AUTO_OFF = 50_000_000,
  parameter int TMO_W = 32
) (
  input logic clk,
  input logic rst,
  note_voice_if.slave bus
);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int LW = $clog2(NUM_VOICES+1);
  localparam logic [63:0] K = 64'(CLK_HZ) * 64'd50;
  function automatic logic [CNT_W-1:0] half_of(input logic [4:0] n);
    case (n)
      5'd1: return CNT_W'(K / 64'd23308);
      5'd2: return CNT_W'(K / 64'd24694);
      5'd3: return CNT_W'(K / 64'd26163);
      5'd4: return CNT_W'(K / 64'd27718);
      5'd5: return CNT_W'(K / 64'd29366);
      5'd6: return CNT_W'(K / 64'd31113);
      5'd7: return CNT_W'(K / 64'd32963);
      5'd8: return CNT_W'(K / 64'd34923);
      5'd9: return CNT_W'(K / 64'd36999);
      5'd10: return CNT_W'(K / 64'd39200);
      5'd11: return CNT_W'(K / 64'd41530);
      5'd12: return CNT_W'(K / 64'd44000);
      5'd13: return CNT_W'(K / 64'd46616);
      5'd14: return CNT_W'(K / 64'd49388);
      5'd15: return CNT_W'(K / 64'd52325);
      default: return CNT_W'(K / 64'd55437);
    endcase
  endfunction
  logic [NUM_VOICES-1:0] act, sq, wrap, expire;
  logic [4:0] code [NUM_VOICES];
  logic [CNT_W-1:0] cnt [NUM_VOICES];
  logic [TMO_W-1:0] hold [NUM_VOICES];
  logic [IW-1:0] sp, hit_idx, free_idx, tgt;
  logic hit_any, free_any, off, legal, drop_q, out_q, unused_bits;
  logic [LW-1:0] lvl, level_q;
  logic [4:0] c;
  assign c = bus.rx_data[4:0];
  assign off = bus.rx_data[7];
  assign legal = c <= 5'd16;
  assign unused_bits = ^bus.rx_data[6:5];
  assign tgt = hit_any ? hit_idx : free_any ? free_idx : sp;
  always_comb begin
    hit_any = 1'b0;
    free_any = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    lvl = '0;
    wrap = '0;
    expire = '0;
    for (int i = NUM_VOICES-1; i >= 0; i--) begin
      if (act[i] && code[i] == c) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!act[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      lvl = lvl + LW'(sq[i]);
      wrap[i] = cnt[i] == half_of(code[i]) - 1'b1;
      expire[i] = AUTO_OFF != 0 && hold[i] == TMO_W'(AUTO_OFF-1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= '0;
      sq <= '0;
      sp <= '0;
      level_q <= '0;
      out_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        code[i] <= '0;
        cnt[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      level_q <= lvl;
      out_q <= |sq;
      drop_q <= bus.rx_valid && !legal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (act[i] && expire[i]) begin
          act[i] <= 1'b0;
          sq[i] <= 1'b0;
          cnt[i] <= '0;
          hold[i] <= '0;
        end else if (act[i]) begin
          cnt[i] <= wrap[i] ? '0 : cnt[i] + 1'b1;
          sq[i] <= sq[i] ^ wrap[i];
          hold[i] <= hold[i] + 1'b1;
        end
      end
      if (bus.rx_valid && legal) begin
        if (c == 5'd0) begin
          act <= '0;
          sq <= '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            cnt[i] <= '0;
            hold[i] <= '0;
          end
        end else if (!off) begin
          act[tgt] <= 1'b1;
          sq[tgt] <= 1'b0;
          code[tgt] <= c;
          cnt[tgt] <= '0;
          hold[tgt] <= '0;
          if (!hit_any && !free_any) sp <= sp == IW'(NUM_VOICES-1) ? '0 : sp + 1'b1;
        end else if (hit_any) begin
          act[hit_idx] <= 1'b0;
          sq[hit_idx] <= 1'b0;
          cnt[hit_idx] <= '0;
          hold[hit_idx] <= '0;
        end
      end
    end
  end
  assign bus.voice_active = act;
  assign bus.voice_sq = sq;
  assign bus.audio_level = level_q;
  assign bus.audio_out = out_q;
  assign bus.cmd_drop = drop_q;
endmodule

// File: tb/tb_note_voice_engine.sv
// tb_note_voice_engine: scoreboard bench for note_voice_engine allocation, stealing, retrigger, drops, auto-off and reset
module tb_note_voice_engine;
  localparam int CLK = 100_000;
  localparam int NV = 4;
  localparam int AO = 1000;
  localparam int HA4 = CLK * 50 / 44000;
  localparam int HC4 = CLK * 50 / 26163;
  typedef struct {
    string tag;
    logic [3:0] act;
    logic drop;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  note_voice_if #(.NUM_VOICES(NV)) bus();
  note_voice_engine #(.CLK_HZ(CLK), .NUM_VOICES(NV), .AUTO_OFF(AO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input string tag, input logic [7:0] b, input logic [3:0] act, input logic drop);
    exp_t e;
    e.tag = tag;
    e.act = act;
    e.drop = drop;
    sb.push_back(e);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic sq_after(input int n, input string tag, input logic v);
    repeat (n) @(posedge clk);
    #1 check(tag, 32'(bus.voice_sq[0]), 32'(v));
  endtask
  always @(posedge clk) begin
    exp_t e;
    if (bus.rx_valid && !rst) begin
      #1;
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        check({e.tag, "_act"}, 32'(bus.voice_active), 32'(e.act));
        check({e.tag, "_drop"}, 32'(bus.cmd_drop), 32'(e.drop));
      end
    end
  end
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_act", 32'(bus.voice_active), 0);
    check("rst_sq", 32'(bus.voice_sq), 0);
    check("rst_lvl", 32'(bus.audio_level), 0);
    check("rst_out", 32'(bus.audio_out), 0);
    check("rst_drop", 32'(bus.cmd_drop), 0);
    @(negedge clk);
    rst = 1'b0;
    send("a4_on", 8'h0C, 4'b0001, 1'b0);
    sq_after(HA4 - 1, "a4_pre", 1'b0);
    sq_after(1, "a4_tog1", 1'b1);
    check("a4_out_lag", 32'(bus.audio_out), 0);
    @(posedge clk);
    #1;
    check("a4_out", 32'(bus.audio_out), 1);
    check("a4_lvl", 32'(bus.audio_level), 1);
    sq_after(HA4 - 2, "a4_hi", 1'b1);
    sq_after(1, "a4_tog2", 1'b0);
    do_reset();
    send("c4_on", 8'h03, 4'b0001, 1'b0);
    sq_after(HC4 - 1, "c4_pre", 1'b0);
    sq_after(1, "c4_tog", 1'b1);
    do_reset();
    send("al3", 8'h03, 4'b0001, 1'b0);
    send("al5", 8'h05, 4'b0011, 1'b0);
    send("al7", 8'h07, 4'b0111, 1'b0);
    send("al8", 8'h08, 4'b1111, 1'b0);
    send("steal10", 8'h0A, 4'b1111, 1'b0);
    send("off3_gone", 8'h83, 4'b1111, 1'b0);
    send("steal12", 8'h0C, 4'b1111, 1'b0);
    send("off5_gone", 8'h85, 4'b1111, 1'b0);
    send("off10", 8'h8A, 4'b1110, 1'b0);
    send("off12", 8'h8C, 4'b1100, 1'b0);
    send("alloff", 8'h00, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("alloff_lvl", 32'(bus.audio_level), 0);
    check("alloff_out", 32'(bus.audio_out), 0);
    do_reset();
    send("rt_first", 8'h0C, 4'b0001, 1'b0);
    repeat (399) @(negedge clk);
    check("rt_before", 32'(bus.voice_sq[0]), 1);
    send("rt_again", 8'h0C, 4'b0001, 1'b0);
    check("rt_phase0", 32'(bus.voice_sq[0]), 0);
    sq_after(HA4 - 1, "rt_pre", 1'b0);
    sq_after(1, "rt_tog", 1'b1);
    send("rt_off", 8'h8C, 4'b0000, 1'b0);
    send("rt_off2", 8'h8C, 4'b0000, 1'b0);
    send("il_on1", 8'h01, 4'b0001, 1'b0);
    send("il_15", 8'h15, 4'b0001, 1'b1);
    @(posedge clk);
    #1 check("il_pulse", 32'(bus.cmd_drop), 0);
    send("il_f5", 8'hF5, 4'b0001, 1'b1);
    send("ign65", 8'h62, 4'b0011, 1'b0);
    send("on3", 8'h03, 4'b0111, 1'b0);
    send("alloff0", 8'h00, 4'b0000, 1'b0);
    send("on5", 8'h05, 4'b0001, 1'b0);
    send("alloff80", 8'h80, 4'b0000, 1'b0);
    do_reset();
    send("ao_on", 8'h01, 4'b0001, 1'b0);
    repeat (998) @(negedge clk);
    check("ao_998", 32'(bus.voice_active), 1);
    @(negedge clk);
    check("ao_999", 32'(bus.voice_active), 1);
    @(negedge clk);
    check("ao_1000", 32'(bus.voice_active), 0);
    send("ao_on2", 8'h01, 4'b0001, 1'b0);
    repeat (999) @(negedge clk);
    send("ao_race", 8'h01, 4'b0001, 1'b0);
    repeat (999) @(negedge clk);
    check("ao_rt_999", 32'(bus.voice_active), 1);
    @(negedge clk);
    check("ao_rt_1000", 32'(bus.voice_active), 0);
    send("mr_on1", 8'h01, 4'b0001, 1'b0);
    send("mr_on2", 8'h02, 4'b0011, 1'b0);
    rst = 1'b1;
    bus.rx_data = 8'h15;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mr_act", 32'(bus.voice_active), 0);
    check("mr_sq", 32'(bus.voice_sq), 0);
    check("mr_drop", 32'(bus.cmd_drop), 0);
    check("mr_lvl", 32'(bus.audio_level), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mr_after", 32'(bus.voice_active), 0);
    check("mr_out", 32'(bus.audio_out), 0);
    check("sb_left", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
